// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues credit-limited imem requests, buffers responses
// in a FIFO and drives one registered instruction per cycle. Optional macro: FETCH_MISALIGN_TRAP_EN.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        system_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic        fetch_misalign,
`endif
  output logic        instr_valid
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Handshake: a request is accepted on any edge where imem_req & imem_gnt; imem_addr is held until
  // then. Responses (imem_rvalid) return in request order, at least one cycle after their grant.
  logic [31:0]      fetch_pc;
  logic [31:0]      resp_pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] fifo_count;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [63:0]      fifo_mem [FIFO_DEPTH];
  logic [CNT_W:0]   credit_used;
  logic [31:0]      redirect_target;
  logic             gnt_fire;
  logic             push;
  logic             pop;
  logic             trap_block;

  assign redirect_target = {redirect_pc[31:2], 2'b00};

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q;
  assign trap_block     = misalign_q;
  assign fetch_misalign = misalign_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_q <= 1'b0;
    end else if (redirect_valid) begin
      misalign_q <= (redirect_pc[1:0] != 2'b00);
    end
  end
`else
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign trap_block           = 1'b0;
`endif

  // Credits cover both in-flight requests and buffered words, so the FIFO can never overflow.
  assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem_req    = !reset && !redirect_valid && !trap_block &&
                       (credit_used < (CNT_W+1)'(FIFO_DEPTH));
  assign imem_addr   = fetch_pc;
  assign gnt_fire    = imem_req && imem_gnt;
  assign push        = imem_rvalid && (drop_cnt == '0) && !redirect_valid;
  assign pop         = !system_stall && !redirect_valid && !trap_block && (fifo_count != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (redirect_valid) begin
      // A response landing with the redirect is itself discarded, so it is not counted as stale.
      fetch_pc    <= redirect_target;
      resp_pc     <= redirect_target;
      outstanding <= outstanding - CNT_W'(imem_rvalid);
      drop_cnt    <= outstanding - CNT_W'(imem_rvalid);
    end else begin
      if (gnt_fire) fetch_pc <= fetch_pc + 32'd4;
      if (push) resp_pc <= resp_pc + 32'd4;
      outstanding <= outstanding + CNT_W'(gnt_fire) - CNT_W'(imem_rvalid);
      if (imem_rvalid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || redirect_valid) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {resp_pc, imem_rdata};
  end

  // A word pushed into an empty FIFO is not bypassed; it reaches the decoder one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      instruction <= NOP_INSTR;
      instr_pc    <= 32'h0;
      instr_valid <= 1'b0;
    end else if (redirect_valid || trap_block) begin
      instruction <= NOP_INSTR;
      instr_valid <= 1'b0;
    end else if (!system_stall) begin
      if (pop) begin
        {instr_pc, instruction} <= fifo_mem[rd_ptr];
        instr_valid             <= 1'b1;
      end else begin
        instruction <= NOP_INSTR;
        instr_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: in-order memory model with stale tracking, expected-word scoreboard,
// directed scenarios followed by random traffic.
module tb_instr_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        system_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        instr_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_misalign;
  logic        exp_misalign;
`endif

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .system_stall   (system_stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instruction    (instruction),
    .instr_pc       (instr_pc),
`ifdef FETCH_MISALIGN_TRAP_EN
    .fetch_misalign (fetch_misalign),
`endif
    .instr_valid    (instr_valid)
  );

  logic [63:0] exp_q[$];
  logic [31:0] pend_addr[$];
  logic        pend_stale[$];
  int          checks = 0;
  int          passed = 0;
  int          cyc = 0;
  int          grants = 0;
  int          first_req_cyc = -1;
  int          first_valid_cyc = -1;
  logic [31:0] exp_fetch_pc;
  logic [31:0] prev_instr;
  logic [31:0] prev_pc;
  logic        prev_valid;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A3C_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One clock: drive inputs at the falling edge, act as memory, then sample after the rising edge.
  task automatic cycle(input logic stall_i, input logic redir_i, input logic [31:0] rpc_i,
                       input logic gnt_i, input logic rsp_i);
    int          out_before;
    logic [31:0] a;
    logic        st;
    logic [63:0] e;
    out_before     = pend_addr.size();
    system_stall   = stall_i;
    redirect_valid = redir_i;
    redirect_pc    = rpc_i;
    imem_gnt       = gnt_i;
    imem_rvalid    = 1'b0;
    if (redir_i) begin
      foreach (pend_stale[i]) pend_stale[i] = 1'b1;
      exp_q.delete();
      exp_fetch_pc = {rpc_i[31:2], 2'b00};
`ifdef FETCH_MISALIGN_TRAP_EN
      exp_misalign = (rpc_i[1:0] != 2'b00);
`endif
    end
    if (rsp_i && pend_addr.size() > 0) begin
      a           = pend_addr.pop_front();
      st          = pend_stale.pop_front();
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(a);
      if (!st) exp_q.push_back({a, mem_word(a)});
    end
    #1;
    check("credit", 32'(imem_req && out_before >= 4), 32'd0);
    if (redir_i) check("req_on_redirect", 32'(imem_req), 32'd0);
    if (imem_req && first_req_cyc < 0) first_req_cyc = cyc;
    if (imem_req && gnt_i) begin
      check("imem_addr", imem_addr, exp_fetch_pc);
      pend_addr.push_back(exp_fetch_pc);
      pend_stale.push_back(1'b0);
      exp_fetch_pc = exp_fetch_pc + 32'd4;
      grants++;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (!redir_i && !stall_i && instr_valid) begin
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_instr", 32'(instr_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("instr_pc", instr_pc, e[63:32]);
        check("instruction", instruction, e[31:0]);
      end
    end
    if (stall_i && !redir_i) begin
      check("stall_instr", instruction, prev_instr);
      check("stall_pc", instr_pc, prev_pc);
      check("stall_valid", 32'(instr_valid), 32'(prev_valid));
    end
    if (!instr_valid) check("nop_when_invalid", instruction, NOP);
    if (redir_i) check("valid_after_redirect", 32'(instr_valid), 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("fetch_misalign", 32'(fetch_misalign), 32'(exp_misalign));
    if (exp_misalign) begin
      check("trap_req", 32'(imem_req), 32'd0);
      check("trap_valid", 32'(instr_valid), 32'd0);
    end
`endif
    prev_instr = instruction;
    prev_pc    = instr_pc;
    prev_valid = instr_valid;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (pend_addr.size() > 0 || exp_q.size() > 0); i++)
      cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    check("drain_pending", 32'(pend_addr.size()), 32'd0);
    check("drain_expected", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset          = 1'b1;
    system_stall   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    exp_fetch_pc   = 32'h0;
`ifdef FETCH_MISALIGN_TRAP_EN
    exp_misalign   = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_req", 32'(imem_req), 32'd0);
    check("reset_instruction", instruction, NOP);
    check("reset_instr_pc", instr_pc, 32'h0);
    check("reset_valid", 32'(instr_valid), 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("reset_misalign", 32'(fetch_misalign), 32'd0);
`endif
    prev_instr = instruction;
    prev_pc    = instr_pc;
    prev_valid = instr_valid;
    reset      = 1'b0;

    // Streaming with single-cycle memory latency.
    repeat (8) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    check("first_valid_latency", 32'(first_valid_cyc - first_req_cyc), 32'd3);
    drain();

    // Memory that never answers: credit stops issue at four.
    grants = 0;
    repeat (8) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    check("grants_without_resp", 32'(grants), 32'd4);
    check("req_out_of_credit", 32'(imem_req), 32'd0);
    check("valid_without_resp", 32'(instr_valid), 32'd0);
    check("nop_without_resp", instruction, NOP);
    drain();

    // Stall while responses fill the FIFO.
    repeat (5) cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    check("req_fifo_full", 32'(imem_req), 32'd0);
    repeat (12) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    drain();

    // Redirect with three stale requests in flight.
    cycle(1'b0, 1'b1, 32'h10, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    check("outstanding_before_redirect", 32'(pend_addr.size()), 32'd3);
    cycle(1'b0, 1'b1, 32'h200, 1'b0, 1'b1);
    check("post_redirect_addr", imem_addr, 32'h200);
    repeat (10) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    drain();

    // PC wrap through the top of the address space.
    cycle(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0);
    repeat (8) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    drain();

`ifdef FETCH_MISALIGN_TRAP_EN
    cycle(1'b0, 1'b1, 32'h102, 1'b0, 1'b0);
    repeat (4) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    check("trap_no_grants", 32'(pend_addr.size()), 32'd0);
    cycle(1'b0, 1'b1, 32'h100, 1'b0, 1'b0);
    check("resume_addr", imem_addr, 32'h100);
    repeat (6) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    drain();
`endif

    // Random traffic with stalls and redirects.
    for (int i = 0; i < 300; i++) begin
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
            32'($urandom_range(0, 32'h3FF)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 2) != 0);
    end
    cycle(1'b0, 1'b1, 32'h400, 1'b0, 1'b0);
    repeat (6) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front-end stage directly upstream of the decoder. Owns the program counter and issues in-order word fetches to instruction memory over a request/grant/response handshake.
- Buffers returned words in a small FIFO. Presents one registered instruction per cycle to the decoder's `instruction` input.
- Honours `system_stall` and branch/jump redirects from execute. Discards stale in-flight responses after a redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FIFO_DEPTH, 4, instruction buffer entries; power of 2, minimum 2.
- NOP_INSTR, 32'h0000_0013, word driven on `instruction` when nothing valid (`addi x0,x0,0`).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- system_stall  in  1  hold decoder-facing outputs and suppress FIFO pop.
- redirect_valid  in  1  execute-stage taken branch/jump this cycle.
- redirect_pc  in  32  target PC for redirect.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  word address of the request (byte address, [1:0]=0).
- imem_gnt  in  1  request accepted when `imem_req & imem_gnt`.
- imem_rvalid  in  1  response valid; responses arrive in request order, latency ≥1 cycle.
- imem_rdata  in  32  response instruction word.
- instruction  out  32  instruction to decoder.
- instr_pc  out  32  PC of `instruction`.
- instr_valid  out  1  `instruction` is a real fetched word.

Behaviour:
- Reset:
  - fetch_pc=RESET_PC; FIFO empty; outstanding=0; drop_cnt=0.
  - imem_req=0; instruction=NOP_INSTR; instr_pc=0; instr_valid=0.
  - Reset mid-transaction abandons all in-flight responses. Memory is reset with the core, so no late responses are expected.
- Issue:
  - imem_req=1 when !reset, !redirect_valid, and (outstanding + fifo_count) < FIFO_DEPTH. This credit rule means the FIFO never overflows.
  - imem_addr=fetch_pc (combinational from the register).
  - On grant: fetch_pc += 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0), and outstanding += 1.
  - req may stay high across cycles; addr changes only after a grant.
- Response:
  - On imem_rvalid with drop_cnt>0: discard the word, drop_cnt -= 1, outstanding -= 1.
  - Otherwise: push {pc_of_resp, imem_rdata} into the FIFO and outstanding -= 1.
  - pc_of_resp comes from a resp_pc counter that increments by 4 per accepted (non-dropped) response and is loaded on redirect.
  - Grant and response in the same cycle: outstanding unchanged.
- Output register, updated only when !system_stall:
  - FIFO non-empty: pop head into instruction/instr_pc; instr_valid=1.
  - FIFO empty: instruction=NOP_INSTR, instr_pc holds, instr_valid=0.
  - Push to empty FIFO and pop in the same cycle: the word is not bypassed; it appears the next cycle. Fetch-to-decoder latency is therefore ≥2 cycles after rvalid.
  - When system_stall=1, all three outputs hold and the FIFO does not pop. Issue and response acceptance continue within credit.
- Redirect (highest priority; overrides stall for the flush only):
  - fetch_pc and resp_pc load redirect_pc; FIFO flushed.
  - instruction=NOP_INSTR, instr_valid=0.
  - drop_cnt = outstanding − (1 if a response arrives this cycle). That response is discarded.
  - imem_req is forced to 0 that cycle, so no grant coincides with a redirect.
  - First fetch to the new target is issued the next cycle.
  - redirect_pc[1:0] are ignored (forced to 0) unless the optional feature is enabled.
- Back-to-back redirects: each recomputes drop_cnt from the current outstanding count. The last redirect wins.

Optional Feature:
- Macro FETCH_MISALIGN_TRAP_EN.
- Defined:
  - Adds output `fetch_misalign` (1 bit, reset 0).
  - A redirect with redirect_pc[1:0]!=0 sets fetch_misalign=1 and loads fetch_pc={redirect_pc[31:2],2'b00}.
  - Issue is blocked (imem_req=0) until the next valid redirect or reset clears the flag.
  - Outputs show NOP_INSTR with instr_valid=0 while the flag is set.
- Undefined: no extra port; low bits are silently truncated.

Test Plan:
- Reset release, imem grants every cycle, 1-cycle latency returning words A0..A3 -> imem_addr 0,4,8,12; instruction=A0 with instr_pc=0 and instr_valid=1 exactly 3 cycles after first req; then one word per cycle.
- Memory never returns data -> exactly FIFO_DEPTH=4 grants, then imem_req=0; instr_valid stays 0; instruction=32'h00000013.
- Hold system_stall=1 for 5 cycles while responses arrive -> outputs frozen; FIFO fills to 4; req drops; after release, words drain in order with consecutive PCs.
- 3 requests outstanding at 0x10,0x14,0x18; redirect_pc=0x200 -> three responses discarded; next instr_valid word has instr_pc=0x200; first post-redirect imem_addr=0x200.
- fetch_pc=32'hFFFF_FFFC granted -> next imem_addr=0x0; instr_pc sequence FFFF_FFFC, 0000_0000.
- With FETCH_MISALIGN_TRAP_EN: redirect_pc=0x102 -> fetch_misalign=1 next cycle and imem_req=0; later redirect 0x100 -> flag clears and fetch resumes at 0x100.
